// File: rtl/mult_div_unit_if.sv
// Operand/result and start/done handshake bundle between the MIPS datapath and mult_div_unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mult_start;
    logic             div_start;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output A, B, mult_start, div_start, input busy, done, div_zero, hi, lo);
    modport slave  (input A, B, mult_start, div_start, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed Booth multiplier / restoring divider owning HI and LO.
// Divide path compiled in only when MULT_DIV_DIV_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int            CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_MULT = 2'd1;
`ifdef MULT_DIV_DIV_EN
    localparam logic [1:0]    S_DIV  = 2'd2;
`endif
    localparam logic [1:0]    S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    // Booth register {acc (WIDTH+1), multiplier (WIDTH), q_-1}; the extra acc bit absorbs -(-2^(WIDTH-1))
    logic signed [2*WIDTH+1:0] booth_q, booth_d, booth_step;
    logic signed [WIDTH:0]     mcand_q, mcand_d, acc_sum;

    always_comb begin
        acc_sum = booth_q[2*WIDTH+1:WIDTH+1];
        case (booth_q[1:0])
            2'b01:   acc_sum = booth_q[2*WIDTH+1:WIDTH+1] + mcand_q;
            2'b10:   acc_sum = booth_q[2*WIDTH+1:WIDTH+1] - mcand_q;
            default: acc_sum = booth_q[2*WIDTH+1:WIDTH+1];
        endcase
        booth_step = $signed({acc_sum, booth_q[WIDTH:0]}) >>> 1;
    end

`ifdef MULT_DIV_DIV_EN
    logic [WIDTH-1:0] dvsr_q, dvsr_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH:0]   trial_shift, trial;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             div_zero_q, div_zero_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    // Quotient is shifted out of quo_q into the partial remainder; a borrow means restore
    always_comb begin
        trial_shift = {rem_q, quo_q[WIDTH-1]};
        trial       = trial_shift - {1'b0, dvsr_q};
        rem_step    = trial[WIDTH] ? trial_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end
`else
    logic unused_div_start;
    assign unused_div_start = bus.div_start;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        booth_d = booth_q;
        mcand_d = mcand_q;
`ifdef MULT_DIV_DIV_EN
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        div_zero_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.mult_start) begin
                    mcand_d = {bus.A[WIDTH-1], bus.A};
                    booth_d = {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
                    cnt_d   = '0;
                    state_d = S_MULT;
`ifdef MULT_DIV_DIV_EN
                end else if (bus.div_start) begin
                    if (bus.B == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        dvsr_d  = magnitude(bus.B);
                        quo_d   = magnitude(bus.A);
                        rem_d   = '0;
                        qneg_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        rneg_d  = bus.A[WIDTH-1];
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
`endif
                end
            end
            S_MULT: begin
                booth_d = booth_step;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    {hi_d, lo_d} = booth_step[2*WIDTH:1];
                    state_d      = S_DONE;
                end
            end
`ifdef MULT_DIV_DIV_EN
            S_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    lo_d    = apply_sign(quo_step, qneg_q);
                    hi_d    = apply_sign(rem_step, rneg_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            booth_q <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            booth_q <= booth_d;
            mcand_q <= mcand_d;
        end
    end

`ifdef MULT_DIV_DIV_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q == S_MULT) || (state_q == S_DIV);
    assign bus.div_zero = div_zero_q;
`else
    assign bus.busy     = (state_q == S_MULT);
    assign bus.div_zero = 1'b0;
`endif
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: randomized operands against an arithmetic model of HI/LO.
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int WIN = W + 8;

    logic clk = 1'b0;
    logic reset;
    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint q, r;
        logic [63:0] qv, rv;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        qv = q;
        rv = r;
        return {rv[W-1:0], qv[W-1:0]};
    endfunction

    task automatic do_op(input logic mul, input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int done_at, output int busy_cyc, output int done_cnt, output int dz_cnt,
                         output int vis_bad, output logic [W-1:0] hi_v, output logic [W-1:0] lo_v,
                         output logic dz_v);
        done_at = -1; busy_cyc = 0; done_cnt = 0; dz_cnt = 0; vis_bad = 0;
        hi_v = '0; lo_v = '0; dz_v = 1'b0;
        @(posedge clk); #1;
        bus.A = a; bus.B = b; bus.mult_start = mul; bus.div_start = div;
        @(posedge clk); #1;
        bus.mult_start = 1'b0; bus.div_start = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        for (int c = 1; c <= WIN; c++) begin
            if (bus.busy) busy_cyc++;
            if (bus.div_zero) dz_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c; hi_v = bus.hi; lo_v = bus.lo; dz_v = bus.div_zero;
                end
            end else if (done_at < 0 && (bus.hi !== exp_hi || bus.lo !== exp_lo)) begin
                vis_bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.A = '0; bus.B = '0; bus.mult_start = 1'b0; bus.div_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/div_zero=%b required 000", {bus.busy, bus.done, bus.div_zero});
        end
        n_tests++;
        if ({bus.hi, bus.lo} !== {2*W{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0", bus.hi, bus.lo);
        end
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_mult();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic [W-1:0] a, b, hi_v, lo_v;
        logic [2*W-1:0] exp;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad;
        ta = '{32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
        tb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h7FFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 24; i++) begin
            a = (i < 8) ? ta[i] : W'($urandom);
            b = (i < 8) ? tb[i] : W'($urandom);
            do_op(1'b1, 1'b0, a, b, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
            exp = ref_mult(a, b);
            n_tests++;
            if ({done_at, busy_cyc, done_cnt, dz_cnt, vis_bad} !== {W + 1, W, 1, 0, 0}) begin
                n_fail++;
                $display("FAIL mult[%0d]_timing: done_at=%0d busy=%0d dones=%0d dz=%0d early_change=%0d required %0d %0d 1 0 0",
                         i, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, W + 1, W);
            end
            n_tests++;
            if ({hi_v, lo_v} !== exp) begin
                n_fail++;
                $display("FAIL mult[%0d]_result: a=%h b=%h got hi=%h lo=%h required %h", i, a, b, hi_v, lo_v, exp);
            end
            exp_hi = exp[2*W-1:W]; exp_lo = exp[W-1:0];
            n_tests++;
            if ({bus.hi, bus.lo} !== exp) begin
                n_fail++;
                $display("FAIL mult[%0d]_hold: hi=%h lo=%h required %h", i, bus.hi, bus.lo, exp);
            end
        end
    endtask

`ifdef MULT_DIV_DIV_EN
    task automatic test_div();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic [W-1:0] a, b, hi_v, lo_v;
        logic [2*W-1:0] exp;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad;
        ta = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'h7FFF_FFFF};
        tb = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'd1};
        for (int i = 0; i < 22; i++) begin
            a = (i < 6) ? ta[i] : W'($urandom);
            if (i < 6) b = tb[i];
            else if ($urandom_range(0, 1) == 1) b = W'($urandom);
            else b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 300)) : -W'($urandom_range(1, 300));
            if (b == '0) b = 1;
            do_op(1'b0, 1'b1, a, b, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
            exp = ref_div(a, b);
            n_tests++;
            if ({done_at, busy_cyc, done_cnt, dz_cnt, vis_bad} !== {W + 1, W, 1, 0, 0}) begin
                n_fail++;
                $display("FAIL div[%0d]_timing: done_at=%0d busy=%0d dones=%0d dz=%0d early_change=%0d required %0d %0d 1 0 0",
                         i, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, W + 1, W);
            end
            n_tests++;
            if ({hi_v, lo_v} !== exp) begin
                n_fail++;
                $display("FAIL div[%0d]_result: a=%h b=%h got hi=%h lo=%h required %h", i, a, b, hi_v, lo_v, exp);
            end
            exp_hi = exp[2*W-1:W]; exp_lo = exp[W-1:0];
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] a, b, hi_v, lo_v;
        logic [2*W-1:0] exp;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom);
            do_op(1'b1, 1'b0, a, b, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
            exp = ref_mult(a, b);
            exp_hi = exp[2*W-1:W]; exp_lo = exp[W-1:0];
            do_op(1'b0, 1'b1, W'($urandom), '0, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
            n_tests++;
            if ({done_at, busy_cyc, done_cnt, dz_cnt, 31'd0, dz_v} !== {1, 0, 1, 1, 32'd1}) begin
                n_fail++;
                $display("FAIL divzero[%0d]_timing: done_at=%0d busy=%0d dones=%0d dz_pulses=%0d dz_at_done=%b required 1 0 1 1 1",
                         i, done_at, busy_cyc, done_cnt, dz_cnt, dz_v);
            end
            n_tests++;
            if ({hi_v, lo_v, bus.hi, bus.lo} !== {exp_hi, exp_lo, exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL divzero[%0d]_hilo: done hi=%h lo=%h after hi=%h lo=%h required hi=%h lo=%h",
                         i, hi_v, lo_v, bus.hi, bus.lo, exp_hi, exp_lo);
            end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [W-1:0] hi_v, lo_v;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 1'b1, W'($urandom), (i == 0) ? '0 : W'($urandom) | 1, done_at, busy_cyc, done_cnt,
                  dz_cnt, vis_bad, hi_v, lo_v, dz_v);
            n_tests++;
            if ({busy_cyc, done_cnt, dz_cnt, vis_bad} !== {0, 0, 0, 0}) begin
                n_fail++;
                $display("FAIL divoff[%0d]: busy=%0d dones=%0d dz=%0d hilo_changes=%0d required all 0",
                         i, busy_cyc, done_cnt, dz_cnt, vis_bad);
            end
        end
    endtask
`endif

    task automatic test_both_starts();
        logic [W-1:0] hi_v, lo_v;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, busy_n;
        do_op(1'b1, 1'b1, 32'd5, 32'd6, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
        n_tests++;
        if ({done_at, done_cnt, hi_v, lo_v} !== {W + 1, 1, 32'd0, 32'd30}) begin
            n_fail++;
            $display("FAIL both_starts: done_at=%0d dones=%0d hi=%h lo=%h required %0d 1 0 1e", done_at, done_cnt, hi_v, lo_v, W + 1);
        end
        exp_hi = '0; exp_lo = 32'd30;
        @(posedge clk); #1;
        bus.A = 32'd5; bus.B = 32'd6; bus.mult_start = 1'b1;
        @(posedge clk); #1;
        bus.mult_start = 1'b0;
        busy_n = 0; done_cnt = 0; done_at = -1; hi_v = '0; lo_v = '0;
        for (int c = 1; c <= WIN; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = c; hi_v = bus.hi; lo_v = bus.lo; end
            end
            bus.div_start = (bus.busy && busy_n == 10);
            bus.A = 32'd100; bus.B = 32'd7;
            @(posedge clk); #1;
        end
        bus.div_start = 1'b0;
        n_tests++;
        if ({done_at, done_cnt, hi_v, lo_v} !== {W + 1, 1, 32'd0, 32'd30}) begin
            n_fail++;
            $display("FAIL start_while_busy: done_at=%0d dones=%0d hi=%h lo=%h required %0d 1 0 1e", done_at, done_cnt, hi_v, lo_v, W + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b, hi_v, lo_v;
        logic [2*W-1:0] exp;
        logic dz_v;
        int done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, busy_n;
        @(posedge clk); #1;
        bus.A = 32'd123457; bus.B = 32'hFFFF_FC19; bus.mult_start = 1'b1;
        @(posedge clk); #1;
        bus.mult_start = 1'b0;
        busy_n = 0;
        for (int c = 1; c <= WIN && busy_n < 15; c++) begin
            if (bus.busy) busy_n++;
            if (busy_n < 15) begin @(posedge clk); #1; end
        end
        n_tests++;
        if (busy_n != 15) begin
            n_fail++;
            $display("FAIL reset_mid_reach: busy cycles seen=%0d required 15", busy_n);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== {3'b000, {2*W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_clear: busy=%b done=%b dz=%b hi=%h lo=%h required all 0",
                     bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        done_cnt = 0;
        for (int c = 0; c < WIN; c++) begin
            if (bus.done || bus.busy) done_cnt++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: busy/done cycles after release=%0d required 0", done_cnt);
        end
        a = W'($urandom); b = W'($urandom);
        do_op(1'b1, 1'b0, a, b, done_at, busy_cyc, done_cnt, dz_cnt, vis_bad, hi_v, lo_v, dz_v);
        exp = ref_mult(a, b);
        n_tests++;
        if ({done_at, done_cnt, hi_v, lo_v} !== {W + 1, 1, exp}) begin
            n_fail++;
            $display("FAIL reset_mid_restart: done_at=%0d dones=%0d hi=%h lo=%h required %0d 1 %h", done_at, done_cnt, hi_v, lo_v, W + 1, exp);
        end
        exp_hi = exp[2*W-1:W]; exp_lo = exp[W-1:0];
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a2, b2, hi_v, lo_v;
        logic [2*W-1:0] exp;
        int done_at, done_cnt, c;
        a2 = W'($urandom); b2 = W'($urandom);
        @(posedge clk); #1;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.mult_start = 1'b1;
        @(posedge clk); #1;
        bus.mult_start = 1'b0;
        c = 0;
        while (!bus.done && c < WIN) begin @(posedge clk); #1; c++; end
        n_tests++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL b2b_first_done: no done within %0d cycles", WIN);
        end
        bus.A = a2; bus.B = b2; bus.mult_start = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_start_in_done: busy=%b done=%b required 00", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.mult_start = 1'b0;
        done_at = -1; done_cnt = 0; hi_v = '0; lo_v = '0;
        for (int k = 1; k <= WIN; k++) begin
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; hi_v = bus.hi; lo_v = bus.lo; end
            end
            @(posedge clk); #1;
        end
        exp = ref_mult(a2, b2);
        n_tests++;
        if ({done_at, done_cnt, hi_v, lo_v} !== {W + 1, 1, exp}) begin
            n_fail++;
            $display("FAIL b2b_second: done_at=%0d dones=%0d hi=%h lo=%h required %0d 1 %h", done_at, done_cnt, hi_v, lo_v, W + 1, exp);
        end
        exp_hi = exp[2*W-1:W]; exp_lo = exp[W-1:0];
    endtask

    initial begin
        test_reset();
        test_mult();
`ifdef MULT_DIV_DIV_EN
        test_div();
        test_div_zero();
`else
        test_div_disabled();
`endif
        test_both_starts();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit that owns the HI and LO registers of the multicycle MIPS datapath. The control FSM launches it for MULT/DIV. It runs for a fixed number of cycles with a start/done handshake, then holds its results. `hi` and `lo` feed the write-back data-source multiplexer directly, which is how MFHI/MFLO reach the register file.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- A  input  WIDTH  operand from rs (multiplicand / dividend)
- B  input  WIDTH  operand from rt (multiplier / divisor)
- mult_start  input  1  request signed multiply; sampled only in IDLE
- div_start  input  1  request signed divide; sampled only in IDLE
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle pulse with done when the divisor was zero
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

## Operation
- States: IDLE, MULT, DIV, DONE.
- **IDLE, mult_start=1:** latch A and B, clear the counter, go to MULT.
- **IDLE, div_start=1, B≠0:** latch A and B, go to DIV.
- **IDLE, div_start=1, B=0:** go straight to DONE with div_zero set; hi and lo are left unchanged.
- **Both starts high in IDLE:** mult_start wins.
- **Starts outside IDLE:** ignored, with no queuing.
- **MULT:** radix-2 Booth on 2·WIDTH-bit working registers; one step per cycle for WIDTH cycles, then DONE.
- **MULT result:** {hi,lo} = full signed 2·WIDTH-bit product A·B.
- **DIV:** restoring division on operand magnitudes, one quotient bit per cycle, WIDTH cycles, then DONE.
- **DIV sign fix-up:** quotient is negated if the operand signs differ. The remainder takes the sign of the dividend, so the quotient truncates toward zero.
- **DIV result:** lo = quotient, hi = remainder.
- **Overflow case:** A=−2^(WIDTH−1), B=−1 gives lo=−2^(WIDTH−1) (wraps), hi=0, and no flag.
- **DONE:**
  - hi and lo take their new values on the edge that enters DONE; div_zero excepted, as above.
  - done=1 for exactly that one state cycle, then the FSM returns to IDLE.
- **Result visibility:** hi and lo change only on entry to DONE. Intermediate working values are never visible on hi/lo.
- **Other HI/LO writers:** MTHI/MTLO are outside this block's scope; hi/lo have no other write path.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0; internal working registers and counter are zero.
- **Reset mid-operation:** takes effect immediately (asynchronous). The operation is abandoned, no done is produced, and hi and lo read 0.
- **Normal latency:** start is sampled at edge k. busy=1 from edge k+1 through edge k+WIDTH. done=1, with new hi/lo, from edge k+WIDTH+1 for one cycle; busy=0 in that cycle.
- **Divide-by-zero latency:** done=1 and div_zero=1 from edge k+1 for one cycle; busy stays 0.
- **Back-to-back:** earliest next start is sampled at the edge after done falls, i.e. while the FSM is in IDLE again.
- **Operand stability:** A and B are only required to be stable in the start cycle.

## Configuration
- Macro MULT_DIV_DIV_EN.
- **Defined:** the DIV state, divide datapath and div_zero are compiled in, as described above.
- **Undefined:**
  - the divide path is removed and div_start is ignored, so no FSM transition occurs;
  - div_zero is tied to 0;
  - the multiply behaviour is unchanged.

## Test plan
- Reset, then mult_start with A=7, B=−3 → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- mult_start with A=0x80000000, B=0x80000000 → hi=0x40000000, lo=0x00000000.
- div_start with A=−7, B=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then A=0x80000000, B=−1 → lo=0x80000000, hi=0.
- Preload hi/lo via a multiply, then div_start with B=0 → the next cycle shows done=1 and div_zero=1, hi/lo unchanged, busy never high.
- Both starts asserted in IDLE (A=5, B=6) → multiply result (lo=30). Then pulse div_start at the 10th busy cycle → ignored, result still lo=30, single done.
- Assert reset at busy cycle 15 of a multiply → outputs are 0 immediately; no done after release; a new mult_start completes normally.
